seq_det_ctrl: RTL and testbench

Frame controller that sequences the team's serial `101` sequence detector (`seq_det`). It accepts parallel words over a valid/ready handshake and serializes each frame MSB-first onto the detector input. It holds the detector in reset between frames, counts the detector's match pulses over each frame and reports a per-frame result. It sits between a word-oriented producer and one `seq_det` instance, driving that instance's `reset`/`inp` and observing its `result`.

---
 rtl/seq_det_ctrl.sv | 150 +++++++++++++++
 tb/tb_seq_det_ctrl.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/seq_det_ctrl.sv
// rtl/seq_det_ctrl.sv - frame controller that serializes words into a 101 sequence detector and counts its matches
module seq_det_ctrl #(
    parameter int WIDTH   = 8,
    parameter int CNT_W   = 8,
    parameter int DET_LAT = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             det_reset,
    output logic             det_inp,
    input  logic             det_result,
    output logic [CNT_W-1:0] match_cnt,
    output logic             frame_done,
    output logic             err,
    output logic             busy
);

    localparam int BCW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int DLW = (DET_LAT > 1) ? $clog2(DET_LAT) : 1;
    localparam logic [BCW-1:0] LAST_BIT   = BCW'(WIDTH - 1);
    localparam logic [DLW-1:0] LAST_DRAIN = DLW'(DET_LAT - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [BCW-1:0]     bitcnt_q, bitcnt_d;
    logic               last_q, last_d;
    logic [DLW-1:0]     drain_q, drain_d;
    logic [DET_LAT-1:0] bv_q, bv_d;
    logic [DET_LAT:0]   bv_ext;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;
    logic               det_reset_q, det_reset_d;
    logic               det_inp_q, det_inp_d;
    logic               frame_done_q, frame_done_d;
    logic               final_bit;
    logic               xfer;

    always_comb begin
        final_bit = (state_q == S_SHIFT) && (bitcnt_q == LAST_BIT);
        in_ready  = (state_q == S_IDLE) || (final_bit && !last_q);
        xfer      = in_valid && in_ready;

        state_d  = state_q;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        last_d   = last_q;
        drain_d  = drain_q;
        err_d    = err_q;
        cnt_d    = cnt_q;

        // bv_q[i] marks that the bit driven i+1 cycles ago was a real frame bit
        bv_ext = {bv_q, state_q == S_SHIFT};
        bv_d   = bv_ext[DET_LAT-1:0];

        if (bv_q[DET_LAT-1] && det_result && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (xfer) begin
                    shreg_d  = in_data;
                    last_d   = in_last;
                    bitcnt_d = '0;
                    cnt_d    = '0;
                    err_d    = 1'b0;
                    state_d  = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (!final_bit) begin
                    shreg_d  = shreg_q << 1;
                    bitcnt_d = bitcnt_q + 1'b1;
                end else if (last_q) begin
                    drain_d = '0;
                    state_d = S_DRAIN;
                end else if (xfer) begin
                    shreg_d  = in_data;
                    last_d   = in_last;
                    bitcnt_d = '0;
                end else begin
                    // underrun: abandon results still travelling through the detector
                    err_d   = 1'b1;
                    bv_d    = '0;
                    cnt_d   = cnt_q;
                    state_d = S_DONE;
                end
            end
            S_DRAIN: begin
                if (drain_q == LAST_DRAIN) begin
                    state_d = S_DONE;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        det_reset_d  = !((state_d == S_SHIFT) || (state_d == S_DRAIN));
        det_inp_d    = (state_d == S_SHIFT) ? shreg_d[WIDTH-1] : 1'b0;
        frame_done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            shreg_q      <= '0;
            bitcnt_q     <= '0;
            last_q       <= 1'b0;
            drain_q      <= '0;
            bv_q         <= '0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            det_reset_q  <= 1'b1;
            det_inp_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            bitcnt_q     <= bitcnt_d;
            last_q       <= last_d;
            drain_q      <= drain_d;
            bv_q         <= bv_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            det_reset_q  <= det_reset_d;
            det_inp_q    <= det_inp_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign det_reset  = det_reset_q;
    assign det_inp    = det_inp_q;
    assign match_cnt  = cnt_q;
    assign err        = err_q;
    assign frame_done = frame_done_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_seq_det_ctrl.sv
// tb/tb_seq_det_ctrl.sv - directed scoreboard bench for seq_det_ctrl with a behavioural 101 detector
module tb_seq_det_ctrl;

    typedef struct {
        int cnt;
        bit err;
        int ofs;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    logic       clock    = 1'b0;
    logic       reset    = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_last  = 1'b0;
    logic [7:0] in_data  = 8'h00;

    logic       in_ready, det_reset, det_inp, frame_done, err, busy;
    logic [7:0] match_cnt;
    logic       det_result = 1'b0;
    logic [1:0] hist = 2'b00;

    logic       in_ready2, det_reset2, det_inp2, frame_done2, err2, busy2;
    logic [1:0] match_cnt2;
    logic       det_result2 = 1'b0;
    logic [1:0] hist2 = 2'b00;

    seq_det_ctrl #(.WIDTH(8), .CNT_W(8), .DET_LAT(1)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .det_reset(det_reset), .det_inp(det_inp),
        .det_result(det_result), .match_cnt(match_cnt), .frame_done(frame_done),
        .err(err), .busy(busy)
    );

    seq_det_ctrl #(.WIDTH(8), .CNT_W(2), .DET_LAT(1)) dut_sat (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
        .in_data(in_data), .in_last(in_last), .det_reset(det_reset2), .det_inp(det_inp2),
        .det_result(det_result2), .match_cnt(match_cnt2), .frame_done(frame_done2),
        .err(err2), .busy(busy2)
    );

    always #5 clock = ~clock;

    // overlapping 101 detector, result one cycle after the completing bit
    always @(posedge clock) begin
        det_result  <= !det_reset && (hist == 2'b10) && det_inp;
        hist        <= det_reset ? 2'b00 : {hist[0], det_inp};
        det_result2 <= !det_reset2 && (hist2 == 2'b10) && det_inp2;
        hist2       <= det_reset2 ? 2'b00 : {hist2[0], det_inp2};
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run_frame(input int n, input logic [7:0] w0, input logic [7:0] w1,
                             input bit under, input int exp_cnt, input bit exp_err);
        logic [15:0] stream;
        logic [15:0] exp_stream;
        int          nbits;
        int          done_at;
        exp_t        e;
        nbits   = under ? 8 : n * 8;
        sb_q.push_back('{exp_cnt, exp_err, under ? 9 : nbits + 2});
        stream  = '0;
        done_at = -1;
        @(negedge clock);
        chk("idle_ready", in_ready, 1);
        in_valid = 1'b1;
        in_data  = w0;
        in_last  = (n == 1) && !under;
        @(posedge clock);
        for (int j = 1; j <= 60; j++) begin
            @(negedge clock);
            if (j == 1) begin
                in_valid = 1'b0;
                chk("det_reset_fall", det_reset, 0);
                chk("busy_shift", busy, 1);
            end
            if (j <= nbits) stream = {stream[14:0], det_inp};
            if (j == 4) chk("ready_mid", in_ready, 0);
            if (j == 8 && (n == 2 || under)) chk("ready_final", in_ready, 1);
            if (j == 8 && n == 2) begin
                in_valid = 1'b1;
                in_data  = w1;
                in_last  = 1'b1;
            end
            if (j == 9) in_valid = 1'b0;
            if (frame_done) begin
                done_at = j;
                break;
            end
        end
        in_valid   = 1'b0;
        e          = sb_q.pop_front();
        exp_stream = (n == 2 && !under) ? {w0, w1} : {8'h00, w0};
        chk("done_cycle", done_at, e.ofs);
        chk("match_cnt", match_cnt, e.cnt);
        chk("err", err, e.err);
        chk("sat_cnt", match_cnt2, (e.cnt > 3) ? 3 : e.cnt);
        chk("sat_done", frame_done2, 1);
        chk("stream", stream, exp_stream);
        chk("done_det_reset", det_reset, 1);
        chk("done_ready", in_ready, 0);
        @(negedge clock);
        chk("done_pulse", frame_done, 0);
        chk("idle_busy", busy, 0);
        chk("hold_cnt", match_cnt, e.cnt);
        chk("hold_err", err, e.err);
    endtask

    initial begin
        bit saw_done;
        @(negedge clock);
        chk("rst_det_reset", det_reset, 1);
        chk("rst_det_inp", det_inp, 0);
        chk("rst_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_cnt", match_cnt, 0);
        chk("rst_err", err, 0);
        @(negedge clock);
        reset = 1'b1;

        run_frame(1, 8'hAB, 8'h00, 1'b0, 3, 1'b0);
        run_frame(2, 8'hA5, 8'h40, 1'b0, 3, 1'b0);
        run_frame(1, 8'hFF, 8'h00, 1'b1, 0, 1'b1);
        run_frame(2, 8'hAA, 8'hAA, 1'b0, 7, 1'b0);

        @(negedge clock);
        in_valid = 1'b1;
        in_data  = 8'hAB;
        in_last  = 1'b1;
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        #1;
        chk("mid_rst_det_reset", det_reset, 1);
        chk("mid_rst_ready", in_ready, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_cnt", match_cnt, 0);
        chk("mid_rst_done", frame_done, 0);
        @(negedge clock);
        reset    = 1'b1;
        saw_done = 1'b0;
        repeat (20) begin
            @(negedge clock);
            saw_done |= frame_done;
        end
        chk("mid_rst_no_done", saw_done, 0);
        run_frame(1, 8'hAB, 8'h00, 1'b0, 3, 1'b0);

        run_frame(1, 8'h05, 8'h00, 1'b0, 1, 1'b0);
        run_frame(1, 8'hA0, 8'h00, 1'b0, 1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
